// File: rtl/ids_bus_arbiter_rr.sv
// ids_bus_arbiter_rr: N-master, single-slave round-robin bus arbiter.
// A master is granted one cycle after it is selected in IDLE, and there is
// always one idle cycle between two owners. The hold counter can force the
// owner off the bus after MAX_HOLD owned cycles while another master waits.
// Reads are tagged with the issuing master and returned READ_LATENCY cycles
// later, even if ownership has changed in the meantime.
// Optional feature macro: ARB_PRIO0_EN. When defined, master 0 wins every
// IDLE selection it requests and is exempt from the forced release.
module ids_bus_arbiter_rr #(
  parameter int XLEN         = 32,
  parameter int NUM_MASTERS  = 2,
  parameter int READ_LATENCY = 1,
  parameter int MAX_HOLD     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_MASTERS-1:0]      i_req,
  output logic [NUM_MASTERS-1:0]      o_gnt,
  input  logic [NUM_MASTERS*XLEN-1:0] i_addr,
  input  logic [NUM_MASTERS-1:0]      i_write,
  input  logic [NUM_MASTERS-1:0]      i_read,
  input  logic [NUM_MASTERS*4-1:0]    i_size,
  input  logic [NUM_MASTERS*XLEN-1:0] i_din,
  output logic [XLEN-1:0]             o_dout,
  output logic [NUM_MASTERS-1:0]      o_rvalid,
  output logic [XLEN-1:0]             o_addr,
  output logic                        o_write,
  output logic                        o_read,
  output logic [3:0]                  o_size,
  output logic [XLEN-1:0]             o_din,
  input  logic [XLEN-1:0]             i_dout
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [HW-1:0]          hold_q, hold_d;

  logic                   sel_found;
  logic [IDW-1:0]         sel_idx;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic [IDW-1:0]         ptr_nxt;
  logic [HW-1:0]          hold_inc;
  logic                   force_rel;
  logic                   gnt_act;

  // Read return pipeline: valid bit and issuing master per stage.
  logic [READ_LATENCY-1:0]          vld_pipe_q;
  logic [READ_LATENCY-1:0][IDW-1:0] id_pipe_q;

  // Pick the first requester at or after the pointer, wrapping.
  always_comb begin : p_sel
    logic [NUM_MASTERS-1:0] rr_req;
    int j;
    rr_req    = i_req;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!sel_found && rr_req[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(j);
      end
    end
`ifdef ARB_PRIO0_EN
    if (i_req[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  // Owner decode, wrapped pointer successor and hold-limit release.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    ptr_nxt  = (owner_q == IDW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    // The limit is checked against the count including the current cycle,
    // so the owner gets exactly MAX_HOLD cycles before yielding.
    force_rel = (MAX_HOLD != 0) && (hold_inc == HW'(MAX_HOLD)) &&
                (|(i_req & ~owner_oh));
`ifdef ARB_PRIO0_EN
    if (owner_q == '0) force_rel = 1'b0;
`endif
  end

  // State, owner, pointer and hold counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: IDLE selects, OWN holds until release or forced out.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_OWN;
          owner_d = sel_idx;
          hold_d  = '0;
        end
      end
      S_OWN: begin
        hold_d = hold_inc;
        if (!i_req[owner_q] || force_rel) begin
          state_d = S_IDLE;
          ptr_d   = ptr_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slave mux driven from the owner register; all zero without a grant.
  always_comb begin
    gnt_act = (state_q == S_OWN);
    o_gnt   = gnt_act ? owner_oh : '0;
    o_addr  = '0;
    o_write = 1'b0;
    o_read  = 1'b0;
    o_size  = '0;
    o_din   = '0;
    if (gnt_act) begin
      o_addr  = i_addr[owner_q*XLEN +: XLEN];
      o_write = i_write[owner_q];
      o_read  = i_read[owner_q];
      o_size  = i_size[owner_q*4 +: 4];
      o_din   = i_din[owner_q*XLEN +: XLEN];
    end
  end

  // Shift issued reads along with their master id; reset drops them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0] <= o_read;
      id_pipe_q[0]  <= owner_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        id_pipe_q[k]  <= id_pipe_q[k-1];
      end
    end
  end

  // Return strobe goes to the master that issued the read.
  always_comb begin
    o_rvalid = '0;
    if (vld_pipe_q[READ_LATENCY-1]) o_rvalid[id_pipe_q[READ_LATENCY-1]] = 1'b1;
    o_dout = i_dout;
  end

endmodule

// File: doc/ids_bus_arbiter_rr.md
Name: ids_bus_arbiter_rr

Overview:
Parametrised N-master, single-slave bus arbiter for the IDS subsystem. It generalises the fixed core/DMA arbitration of the current bus to NUM_MASTERS requesters with round-robin fairness, an optional hold-time limit, and read-return tracking for slaves with fixed read latency. It sits between bus masters (core DMEM port, DMA engines, future PIM DMA channels) and one shared slave port (DMEM or buffer SRAM).

Parameters:
XLEN, 32, address/data width
NUM_MASTERS, 2, number of requesters (2..8)
READ_LATENCY, 1, slave read latency in cycles (1..4)
MAX_HOLD, 16, max consecutive owned cycles while another master waits; 0 = unlimited

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_MASTERS  per-master bus request
o_gnt  out  NUM_MASTERS  one-hot grant, registered
i_addr  in  NUM_MASTERS*XLEN  packed master addresses, master k at [k*XLEN +: XLEN]
i_write  in  NUM_MASTERS  per-master write strobe
i_read  in  NUM_MASTERS  per-master read strobe
i_size  in  NUM_MASTERS*4  packed byte-enable masks
i_din  in  NUM_MASTERS*XLEN  packed write data
o_dout  out  XLEN  slave read data, broadcast to all masters
o_rvalid  out  NUM_MASTERS  read data valid for master k
o_addr  out  XLEN  slave address
o_write  out  1  slave write
o_read  out  1  slave read
o_size  out  4  slave byte enables
o_din  out  XLEN  slave write data
i_dout  in  XLEN  slave read data

Behaviour:
- Clock i_clk; reset i_rst_n asynchronous, active-low. Reset: o_gnt=0, o_rvalid=0, round-robin pointer=0, hold counter=0, state IDLE, read pipeline cleared.
- States: IDLE (no owner), OWN (owner index held in register).
- IDLE: if any i_req, select the first requesting master at or after the pointer (wrapping modulo NUM_MASTERS). Next cycle: OWN, o_gnt one-hot for that master. Grant latency is 1 cycle from request.
- OWN: stays while i_req[owner]=1. On i_req[owner]=0: go to IDLE, o_gnt=0 the next cycle, pointer=owner+1 (wrapping). There is no IDLE->OWN bypass: a one-cycle gap between owners is mandatory.
- Hold counter: resets to 0 on entry to OWN and increments each OWN cycle, saturating at MAX_HOLD. If MAX_HOLD!=0, counter==MAX_HOLD, and any other i_req is high, the grant is forcibly released: IDLE next cycle, pointer=owner+1. If the owner has no competitor it keeps ownership indefinitely.
- Slave mux is combinational from the owner register. With o_gnt[k]=1: o_addr/o_write/o_read/o_size/o_din = master k fields. With no grant: all slave outputs 0. o_write and o_read are forwarded only when the grant is active.
- Read tracking: a READ_LATENCY-deep shift register of {valid, owner id} captures o_read each cycle. When an entry emerges valid, o_rvalid[id]=1 for one cycle; o_dout=i_dout always.
- A read in flight across a grant change or forced release still returns to the master that issued it.
- Simultaneous read and write from a master passes both strobes to the slave unchanged. The arbiter does not check this case.
- Reset asserted mid-transfer: grant drops immediately (async) and in-flight reads are discarded, with no o_rvalid.

Optional Feature:
ARB_PRIO0_EN: when defined, master 0 is selected in IDLE whenever i_req[0]=1, regardless of the pointer, and is exempt from the MAX_HOLD forced release. It is still released when it deasserts i_req. Other masters use round-robin among themselves. When undefined, all masters are equal under pure round-robin.

Test Plan:
- Single master: reset, i_req=2'b01 at cycle 0 -> o_gnt=2'b01 at cycle 1. Read addr 0x100 -> o_read=1, o_addr=0x100, o_rvalid[0]=1 one cycle later with o_dout=i_dout.
- Contention: i_req=2'b11 from IDLE, pointer 0 -> master 0 granted. Drop i_req[0] -> one idle cycle, then o_gnt=2'b10, pointer advances to 0 after master 1 releases.
- Hold limit: MAX_HOLD=4, master 0 holds request, master 1 requests -> master 0 loses grant after 4 owned cycles, master 1 granted two cycles later.
- Read across handover: READ_LATENCY=3, master 0 issues a read on its last owned cycle -> o_rvalid[0] pulses 3 cycles later, while master 1 is owner; o_rvalid[1]=0.
- Async reset mid-read: assert i_rst_n=0 between o_read and data return -> o_gnt=0 and no o_rvalid pulse after reset release.
- ARB_PRIO0_EN: NUM_MASTERS=4, masters 1 and 2 request, master 0 requests during master 1 ownership -> after master 1 releases, master 0 is granted before master 2.
